// File: rtl/wfm_loader.sv
// Streams one frame of samples into the DDS waveform table, one write per accepted sample.
// Frame length is checked against DEPTH; short or long frames are flagged on err.
module wfm_loader #(
    parameter int DEPTH = 1024,
    parameter int OW    = 24,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [OW-1:0] s_data,
    input  logic          s_last,
    output logic          wfm_wea,
    output logic [AW-1:0] wfm_waddr,
    output logic [OW-1:0] wfm_din,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        DISCARD = 2'd2,
        SETTLE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_SHORT = 2'b01,
        ERR_LONG  = 2'b10
    } err_e;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e          state_q;
    err_e            err_q;
    logic [AW-1:0]   cnt_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic            wea_q;
    logic [AW-1:0]   waddr_q;
    logic [OW-1:0]   din_q;

    logic            hs;
    logic            at_last_addr;

    assign hs           = s_valid && ready_q;
    assign at_last_addr = (cnt_q == LAST_ADDR);

    // NOTE: every register here is assigned with <= so all state updates see
    // the pre-edge values; a blocking '=' would let later lines see new values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the write-data/address registers are plain flops, not a
            // memory, so clearing them on reset costs nothing and keeps outputs defined.
            state_q <= IDLE;
            err_q   <= ERR_OK;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wea_q   <= 1'b0;
            waddr_q <= '0;
            din_q   <= '0;
        end else begin
            wea_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                        err_q   <= ERR_OK;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        wea_q   <= 1'b1;
                        waddr_q <= cnt_q;
                        din_q   <= s_data;
                        if (s_last) begin
                            state_q <= SETTLE;
                            ready_q <= 1'b0;
                            if (at_last_addr) begin
                                done_q <= 1'b1;
                            end else begin
                                err_q <= ERR_SHORT;
                            end
                        end else if (at_last_addr) begin
                            // Table is full: swallow the rest of the frame without wrapping.
                            state_q <= DISCARD;
                            err_q   <= ERR_LONG;
                        end else begin
                            cnt_q <= cnt_q + AW'(1);
                        end
                    end
                end
                DISCARD: begin
                    if (hs && s_last) begin
                        state_q <= SETTLE;
                        ready_q <= 1'b0;
                    end
                end
                SETTLE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready   = ready_q;
    assign wfm_wea   = wea_q;
    assign wfm_waddr = waddr_q;
    assign wfm_din   = din_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_wfm_loader.sv
// Directed bench for wfm_loader with DEPTH = 16: table of frame vectors plus
// hand-written reset-abort and reset-with-start sequences.
module tb_wfm_loader;

    localparam int DEPTH = 16;
    localparam int OW    = 24;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          s_valid;
    logic          s_ready;
    logic [OW-1:0] s_data;
    logic          s_last;
    logic          wfm_wea;
    logic [AW-1:0] wfm_waddr;
    logic [OW-1:0] wfm_din;
    logic          busy;
    logic          done;
    logic [1:0]    err;

    wfm_loader #(.DEPTH(DEPTH), .OW(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .wfm_wea   (wfm_wea),
        .wfm_waddr (wfm_waddr),
        .wfm_din   (wfm_din),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor, sampled on the falling edge, away from the active edge.
    int cyc = 0;
    int nwr = 0;
    int wr_addr [64];
    int wr_data [64];
    int n_done = 0;
    int spurious = 0;
    int last_wr_cyc = 0;
    int busy_fall_cyc = 0;
    bit hs_prev = 1'b0;
    bit busy_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (wfm_wea === 1'b1) begin
            if (!hs_prev) spurious++;
            if (nwr < 64) begin
                wr_addr[nwr] = int'(wfm_waddr);
                wr_data[nwr] = int'(wfm_din);
            end
            nwr++;
            last_wr_cyc = cyc;
        end
        if (done === 1'b1) n_done++;
        if (busy_prev && busy === 1'b0) busy_fall_cyc = cyc;
        busy_prev = (busy === 1'b1);
        hs_prev   = (s_valid === 1'b1) && (s_ready === 1'b1);
    end

    task automatic clear_mon();
        nwr = 0;
        n_done = 0;
        spurious = 0;
        last_wr_cyc = 0;
        busy_fall_cyc = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_sample(input int k, input bit last, input bit gaps,
                               input bit with_start, output bit ok);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b1;
        s_data  = OW'(k);
        s_last  = last;
        start   = with_start;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit idle = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                idle = 1'b1;
                break;
            end
        end
        check({name, " idle reached"}, int'(idle), 1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        string name;
        int    len;
        bit    gaps;
        int    start_mid;
        bit    start_settle;
        int    exp_wr;
        int    exp_err;
        int    exp_done;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input vec_t v);
        bit ok;
        int bad;
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= v.len; k++) begin
            send_sample(k, k == v.len, v.gaps, k == v.start_mid, ok);
            if (!ok) begin
                check({v.name, " handshake timeout"}, 0, 1);
                break;
            end
        end
        if (v.start_settle) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_idle(v.name);
        check({v.name, " write count"}, nwr, v.exp_wr);
        bad = 0;
        for (int i = 0; i < nwr && i < 64; i++) begin
            if (wr_addr[i] != i || wr_data[i] != i + 1) bad++;
        end
        check({v.name, " bad writes"}, bad, 0);
        check({v.name, " writes w/o handshake"}, spurious, 0);
        check({v.name, " err"}, int'(err), v.exp_err);
        check({v.name, " done pulses"}, n_done, v.exp_done);
        check({v.name, " s_ready in idle"}, int'(s_ready), 0);
        if (v.exp_err != 2)
            check({v.name, " busy fall after last write"}, busy_fall_cyc - last_wr_cyc, 1);
        repeat (3) @(posedge clk);
        #1;
        check({v.name, " stays idle"}, int'(busy), 0);
    endtask

    initial begin
        bit ok;
        vecs[0] = '{"full",          16, 1'b0, 0, 1'b0, 16, 0, 1};
        vecs[1] = '{"full_gaps",     16, 1'b1, 0, 1'b0, 16, 0, 1};
        vecs[2] = '{"short5",         5, 1'b0, 0, 1'b0,  5, 1, 0};
        vecs[3] = '{"long20",        20, 1'b0, 0, 1'b0, 16, 2, 0};
        vecs[4] = '{"short1",         1, 1'b0, 0, 1'b0,  1, 1, 0};
        vecs[5] = '{"long17",        17, 1'b1, 0, 1'b0, 16, 2, 0};
        vecs[6] = '{"start_ignored", 16, 1'b0, 4, 1'b1, 16, 0, 1};
        vecs[7] = '{"short15",       15, 1'b0, 0, 1'b1, 15, 1, 0};

        rst = 1'b0; start = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", int'(busy), 0);
        check("reset s_ready", int'(s_ready), 0);
        check("reset wea", int'(wfm_wea), 0);
        check("reset waddr", int'(wfm_waddr), 0);
        check("reset din", int'(wfm_din), 0);
        check("reset done", int'(done), 0);
        check("reset err", int'(err), 0);
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("start during reset ignored", int'(busy), 0);
        @(posedge clk); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset lands on the handshake edge of sample 8.
        clear_mon();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 7; k++) send_sample(k, 1'b0, 1'b0, 1'b0, ok);
        s_valid = 1'b1;
        s_data  = OW'(8);
        rst     = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check("abort wea", int'(wfm_wea), 0);
        check("abort waddr", int'(wfm_waddr), 0);
        check("abort din", int'(wfm_din), 0);
        check("abort busy", int'(busy), 0);
        check("abort s_ready", int'(s_ready), 0);
        check("abort err", int'(err), 0);
        check("abort write count", nwr, 7);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wfm_loader.md
WFM_LOADER -- requirements
Module: wfm_loader

Interface
REQ-001 Parameter DEPTH, default 1024: number of waveform-table entries to load per frame; power of two, at least 4.
REQ-002 Parameter OW, default 24: sample width, matching the DDS table width.
REQ-003 Localparam AW = $clog2(DEPTH): table address width.
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 rst  input  1  reset; synchronous, active-low.
REQ-006 start  input  1  single-cycle arm request; honoured only in IDLE.
REQ-007 s_valid  input  1  stream sample valid.
REQ-008 s_ready  output  1  stream ready; a handshake occurs when s_valid and s_ready are both high.
REQ-009 s_data  input  OW  stream sample in two's complement.
REQ-010 s_last  input  1  marks the final sample of a frame.
REQ-011 wfm_wea  output  1  table write enable, to the DDS write port.
REQ-012 wfm_waddr  output  AW  table write address.
REQ-013 wfm_din  output  OW  table write data.
REQ-014 busy  output  1  high while in LOAD, DISCARD or SETTLE; the DDS integration holds the DDS in reset while busy is high.
REQ-015 done  output  1  one-cycle pulse on completion of a correctly sized frame.
REQ-016 err  output  2  frame status: 00 = ok or none, 01 = short, 10 = long; held until the next accepted start.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, DISCARD and SETTLE.
REQ-018 IDLE: s_ready = 0, wfm_wea = 0. If start = 1, the FSM moves to LOAD, clears the address counter to 0 and clears err to 00.
REQ-019 LOAD: s_ready = 1.
REQ-020 Each LOAD handshake SHALL register wfm_wea = 1, wfm_waddr = counter and wfm_din = s_data, all valid on the next cycle. Write latency is exactly 1 cycle.
REQ-021 wfm_wea SHALL be high only in the cycle immediately following a LOAD handshake; otherwise 0.
REQ-022 LOAD handshake with counter < DEPTH-1 and s_last = 0: counter increments by 1.
REQ-023 LOAD handshake with counter = DEPTH-1 and s_last = 1: the write occurs, the FSM goes to SETTLE, and err stays 00.
REQ-024 LOAD handshake with counter < DEPTH-1 and s_last = 1: the write occurs, the FSM goes to SETTLE, and err is set to 01.
REQ-025 LOAD handshake with counter = DEPTH-1 and s_last = 0: the write occurs, the FSM goes to DISCARD, and err is set to 10.
REQ-026 The counter SHALL never wrap; no write to address DEPTH or above, and no aliased write to address 0, SHALL ever occur.
REQ-027 DISCARD: s_ready = 1 and every handshake is consumed without a write. A handshake with s_last = 1 moves the FSM to SETTLE.
REQ-028 SETTLE lasts exactly 1 cycle, so the final table write completes before busy deasserts, and then returns to IDLE.
REQ-029 done SHALL pulse for the single cycle of SETTLE only when err = 00.
REQ-030 start SHALL be ignored in LOAD, DISCARD and SETTLE, with no counter or err change.
REQ-031 s_valid = 0 cycles SHALL stall the FSM with no state change; there is no timeout.
REQ-032 busy SHALL be 1 in LOAD, DISCARD and SETTLE, and 0 in IDLE.
REQ-033 In IDLE, s_data and s_last SHALL be ignored regardless of s_valid.

Reset
REQ-034 While rst = 0 at a clock edge: state = IDLE, counter = 0, s_ready = 0, wfm_wea = 0, wfm_waddr = 0, wfm_din = 0, busy = 0, done = 0, err = 00.
REQ-035 A reset during LOAD SHALL abort the frame. A write registered in the same edge SHALL be suppressed (wfm_wea = 0). Table entries already written are not restored.
REQ-036 start asserted together with rst = 0 SHALL be ignored.

Verification
REQ-037 DEPTH = 16: start, then 16 samples 0x000001..0x000010 with s_last on the 16th -> 16 writes to addresses 0..15 with matching data, each 1 cycle after its handshake; done pulses once; err = 00; busy falls 1 cycle after the last write.
REQ-038 Random s_valid gaps (50 %) over the same frame -> identical write sequence; no write cycle without a preceding handshake.
REQ-039 Short frame, s_last on the 5th sample -> writes to addresses 0..4 only; err = 01; no done pulse; FSM back in IDLE after SETTLE.
REQ-040 Long frame, 20 samples with s_last on the 20th -> writes to addresses 0..15 only; samples 17..20 accepted without writes; err = 10; no done pulse.
REQ-041 rst = 0 asserted at the handshake of sample 8 -> no write to address 7; all outputs at reset values; a subsequent start reloads the table from address 0.
REQ-042 start pulsed mid-LOAD and again in SETTLE -> no effect on counter, err or state.
